conditional_logic_pipe: RTL and testbench
=========================================

# conditional_logic_pipe

Pipelined, parametrised ARM conditional-execution unit for the five-stage processor. It holds the Decode→Execute control register and the condition-flags register, and evaluates the 4-bit condition field in Execute. It gates register, memory, PC and flag writes, then carries the gated controls through the Memory and Writeback pipeline registers. It adds stall/flush handling and a configurable flag width and write-group count for extension flags beyond NZCV.

## Interface
- NUM_FLAGS, 4, total flag bits; the top 4 bits are N,Z,C,V (MSB first). Must be ≥4 and divisible by FLAG_GROUPS.
- FLAG_GROUPS, 2, number of independently enabled flag-write groups. Group g covers bits [(g+1)·W−1 : g·W], where W = NUM_FLAGS/FLAG_GROUPS.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cond_d  in  4  condition field of the instruction in Decode
- flag_w_d  in  FLAG_GROUPS  per-group flag-write request
- pcs_d, reg_w_d, mem_w_d, no_write_d, branch_d, mem_to_reg_d  in  1 each  decoded controls
- stall_e  in  1  hold the Execute register
- flush_e  in  1  load a bubble into the Execute register
- alu_flags_e  in  NUM_FLAGS  flags produced by the ALU in Execute
- cond_ex_e  out  1  condition passed (Execute)
- pc_src_e, branch_taken_e, reg_write_e, mem_write_e  out  1 each  gated Execute controls
- pc_src_m, reg_write_m, mem_write_m, mem_to_reg_m  out  1 each  Memory-stage controls
- pc_src_w, reg_write_w, mem_to_reg_w  out  1 each  Writeback-stage controls
- flags_q  out  NUM_FLAGS  architectural flags register

## Operation
- E register: on each clock edge, captures all *_d inputs. Priority order:
  - flush_e → all controls 0 and cond=AL.
  - else stall_e → hold.
  - else load.
- cond_ex_e is combinational from cond_e and flags_q[NUM_FLAGS-1 -: 4]. Standard ARM table EQ..LE; AL (1110) = 1; 1111 is treated as unconditional (1).
- Gated Execute outputs:
  - pc_src_e = pcs_e & cond_ex_e
  - branch_taken_e = branch_e & cond_ex_e
  - reg_write_e = reg_w_e & ~no_write_e & cond_ex_e
  - mem_write_e = mem_w_e & cond_ex_e
- Flag write: group g updates from alu_flags_e on the clock edge iff flag_w_e[g] & cond_ex_e & ~stall_e. Other groups hold.
- M register: captures the gated E outputs and mem_to_reg_e, unless stall_e is high. In that case M loads a bubble (all 0), so a held instruction writes nothing twice.
- W register: always advances from M (pc_src, reg_write, mem_to_reg).
- Reset clears the E, M and W registers and flags_q to 0. All outputs are therefore 0 at reset, except cond_ex_e: reset cond_e = 0000 (EQ) with Z=0 gives cond_ex_e = 0.

## Timing
- Execute outputs are combinational in the cycle the instruction occupies E. M outputs follow 1 cycle later, W outputs 2 cycles later.
- Flag writes are visible to the next instruction in E (1-cycle turnaround, no forwarding needed).
- A flag-setting instruction never sees its own new flags. While stalled it keeps evaluating against the old flags, because flag writes are suppressed during stall_e.
- stall_e and flush_e asserted together: flush wins, and M still loads a bubble that cycle.
- Reset asserted mid-operation clears everything immediately (asynchronous). First load occurs on the first edge after reset deasserts.

## Structure
- Package cond_pkg holds:
  - enum cond_t for the 16 condition codes;
  - localparams N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0, relative to the NZCV nibble;
  - a packed struct ctrl_t for the pipelined control bundle.
- One combinational sub-module, cond_eval (cond, nzcv → cond_ex). The pipeline and flag registers stay in the top module.

## Test plan
- Reset, then load cond_d=EQ with reg_w_d=1 and flags 0 → reg_write_e=0. Then write Z=1 via an AL instruction with flag_w_d=2'b10, alu_flags_e=4'b0100 → next EQ instruction gives reg_write_e=1; reg_write_m asserts 1 cycle later and reg_write_w 2 cycles later.
- Group independence: flags_q=4'b0000, AL instruction with flag_w=2'b01, alu_flags_e=4'b1111 → flags_q=4'b0011 (NZ untouched).
- Conditional flag set fails: cond=NE with Z=1, flag_w=2'b11, alu_flags_e=4'b1000 → flags_q unchanged; pc_src_e=0, mem_write_e=0.
- stall_e held 2 cycles on an AL instruction with mem_w=1, flag_w=2'b11 → E outputs hold and M is a bubble for both cycles. Flags update only on the release cycle; mem_write_m=1 exactly once.
- flush_e and stall_e together with a pending branch (cond=AL, branch_d=1) → branch_taken_e=0 next cycle, M is a bubble.
- Async reset mid-stream, asserted between edges → all outputs and flags_q drop to 0 without waiting for a clock edge. NUM_FLAGS=6, FLAG_GROUPS=3 rerun shows group 0 = bits[1:0], with NZCV at bits[5:2].

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution pipeline.
//   cond_t      : ARM condition field encodings (EQ..AL, NV)
//   *_IDX       : bit positions inside the NZCV nibble
//   ctrl_t      : decoded controls held in the Execute register
//   mem_ctrl_t  : gated controls held in the Memory register
//   wb_ctrl_t   : controls held in the Writeback register
package cond_pkg;

  localparam int unsigned COND_W = 4;
  localparam int unsigned NZCV_W = 4;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  typedef struct packed {
    logic pcs;
    logic reg_w;
    logic mem_w;
    logic no_write;
    logic branch;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator.
//   cond    in  4  condition field
//   nzcv    in  4  current N,Z,C,V flags (MSB first)
//   cond_ex out 1  condition passed
module cond_eval
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [NZCV_W-1:0] nzcv,
  output logic              cond_ex
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[N_IDX];
  assign z = nzcv[Z_IDX];
  assign c = nzcv[C_IDX];
  assign v = nzcv[V_IDX];

  // Condition table; AL and the NV encoding both execute unconditionally
  always_comb begin
    cond_ex = 1'b1;
    case (cond_t'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ~(n ^ v);
      COND_LT: cond_ex = n ^ v;
      COND_GT: cond_ex = ~z & ~(n ^ v);
      COND_LE: cond_ex = z | (n ^ v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/conditional_logic_pipe.sv
// Conditional-execution unit for the five-stage pipeline: Execute control
// register, flags register, condition check, write gating, and the gated
// controls carried through Memory and Writeback.
//   clk, rst           clock (rising) / async active-high reset
//   cond_d, *_d        decoded condition and controls from Decode
//   flag_w_d           per-group flag-write request
//   stall_e, flush_e   hold / bubble the Execute register
//   alu_flags_e        ALU flags produced in Execute
//   cond_ex_e, *_e     condition result and gated Execute controls
//   *_m, *_w           Memory / Writeback stage controls
//   flags_q            architectural flags (top nibble is NZCV)
module conditional_logic_pipe
  import cond_pkg::*;
#(
  parameter int unsigned NUM_FLAGS   = 4,
  parameter int unsigned FLAG_GROUPS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             cond_d,
  input  logic [FLAG_GROUPS-1:0] flag_w_d,
  input  logic                   pcs_d,
  input  logic                   reg_w_d,
  input  logic                   mem_w_d,
  input  logic                   no_write_d,
  input  logic                   branch_d,
  input  logic                   mem_to_reg_d,
  input  logic                   stall_e,
  input  logic                   flush_e,
  input  logic [NUM_FLAGS-1:0]   alu_flags_e,
  output logic                   cond_ex_e,
  output logic                   pc_src_e,
  output logic                   branch_taken_e,
  output logic                   reg_write_e,
  output logic                   mem_write_e,
  output logic                   pc_src_m,
  output logic                   reg_write_m,
  output logic                   mem_write_m,
  output logic                   mem_to_reg_m,
  output logic                   pc_src_w,
  output logic                   reg_write_w,
  output logic                   mem_to_reg_w,
  output logic [NUM_FLAGS-1:0]   flags_q
);

  localparam int unsigned GROUP_W = NUM_FLAGS / FLAG_GROUPS;

  if ((NUM_FLAGS < NZCV_W) || ((NUM_FLAGS % FLAG_GROUPS) != 0)) begin : g_param_check
    $error("conditional_logic_pipe: NUM_FLAGS must be >= 4 and divisible by FLAG_GROUPS");
  end

  ctrl_t                  ctrl_in_c;
  ctrl_t                  ctrl_e;
  cond_t                  cond_e;
  logic [FLAG_GROUPS-1:0] flag_w_e;
  logic [FLAG_GROUPS-1:0] flag_we_c;
  logic [NUM_FLAGS-1:0]   flags_next_c;
  mem_ctrl_t              mem_in_c;
  mem_ctrl_t              ctrl_m;
  wb_ctrl_t               ctrl_w;

  // Bundle the decoded controls
  always_comb begin
    ctrl_in_c            = '0;
    ctrl_in_c.pcs        = pcs_d;
    ctrl_in_c.reg_w      = reg_w_d;
    ctrl_in_c.mem_w      = mem_w_d;
    ctrl_in_c.no_write   = no_write_d;
    ctrl_in_c.branch     = branch_d;
    ctrl_in_c.mem_to_reg = mem_to_reg_d;
  end

  // Execute register: flush beats stall; a flushed slot is an AL no-op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_e   <= '0;
      cond_e   <= COND_EQ;
      flag_w_e <= '0;
    end else if (flush_e) begin
      ctrl_e   <= '0;
      cond_e   <= COND_AL;
      flag_w_e <= '0;
    end else if (!stall_e) begin
      ctrl_e   <= ctrl_in_c;
      cond_e   <= cond_t'(cond_d);
      flag_w_e <= flag_w_d;
    end
  end

  cond_eval u_cond_eval (
    .cond    (cond_e),
    .nzcv    (flags_q[NUM_FLAGS-1 -: NZCV_W]),
    .cond_ex (cond_ex_e)
  );

  // Gated Execute controls
  assign pc_src_e       = ctrl_e.pcs & cond_ex_e;
  assign branch_taken_e = ctrl_e.branch & cond_ex_e;
  assign reg_write_e    = ctrl_e.reg_w & ~ctrl_e.no_write & cond_ex_e;
  assign mem_write_e    = ctrl_e.mem_w & cond_ex_e;

  // Per-group flag update; suppressed while stalled so a held instruction
  // keeps seeing the flags it entered Execute with
  always_comb begin
    flag_we_c    = '0;
    flags_next_c = flags_q;
    for (int g = 0; g < int'(FLAG_GROUPS); g++) begin
      flag_we_c[g] = flag_w_e[g] & cond_ex_e & ~stall_e;
      if (flag_we_c[g]) begin
        flags_next_c[g*GROUP_W +: GROUP_W] = alu_flags_e[g*GROUP_W +: GROUP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_next_c;
    end
  end

  always_comb begin
    mem_in_c            = '0;
    mem_in_c.pc_src     = pc_src_e;
    mem_in_c.reg_write  = reg_write_e;
    mem_in_c.mem_write  = mem_write_e;
    mem_in_c.mem_to_reg = ctrl_e.mem_to_reg;
  end

  // Memory register: a stalled Execute slot sends a bubble downstream so the
  // held instruction commits exactly once, on its release cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_m <= '0;
    end else if (stall_e) begin
      ctrl_m <= '0;
    end else begin
      ctrl_m <= mem_in_c;
    end
  end

  // Writeback register always advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_w <= '0;
    end else begin
      ctrl_w.pc_src     <= ctrl_m.pc_src;
      ctrl_w.reg_write  <= ctrl_m.reg_write;
      ctrl_w.mem_to_reg <= ctrl_m.mem_to_reg;
    end
  end

  assign pc_src_m     = ctrl_m.pc_src;
  assign reg_write_m  = ctrl_m.reg_write;
  assign mem_write_m  = ctrl_m.mem_write;
  assign mem_to_reg_m = ctrl_m.mem_to_reg;

  assign pc_src_w     = ctrl_w.pc_src;
  assign reg_write_w  = ctrl_w.reg_write;
  assign mem_to_reg_w = ctrl_w.mem_to_reg;

endmodule

// File: tb/tb_conditional_logic_pipe.sv
// Scoreboard bench: two instances (4 flags / 2 groups and 6 flags / 3 groups)
// share the decoded controls; a reference model predicts outputs per cycle.
module tb_conditional_logic_pipe;

  logic       clk;
  logic       rst;
  logic [3:0] cond_d;
  logic       pcs_d, reg_w_d, mem_w_d, no_write_d, branch_d, mem_to_reg_d;
  logic       stall_e, flush_e;
  logic [1:0] flag_w_a;
  logic [3:0] alu_a;
  logic [2:0] flag_w_b;
  logic [5:0] alu_b;

  logic       a_cond_ex_e, a_pc_src_e, a_branch_taken_e, a_reg_write_e, a_mem_write_e;
  logic       a_pc_src_m, a_reg_write_m, a_mem_write_m, a_mem_to_reg_m;
  logic       a_pc_src_w, a_reg_write_w, a_mem_to_reg_w;
  logic [3:0] a_flags_q;
  logic       b_cond_ex_e, b_pc_src_e, b_branch_taken_e, b_reg_write_e, b_mem_write_e;
  logic       b_pc_src_m, b_reg_write_m, b_mem_write_m, b_mem_to_reg_m;
  logic       b_pc_src_w, b_reg_write_w, b_mem_to_reg_w;
  logic [5:0] b_flags_q;

  conditional_logic_pipe #(.NUM_FLAGS(4), .FLAG_GROUPS(2)) dut_a (
    .clk(clk), .rst(rst), .cond_d(cond_d), .flag_w_d(flag_w_a),
    .pcs_d(pcs_d), .reg_w_d(reg_w_d), .mem_w_d(mem_w_d), .no_write_d(no_write_d),
    .branch_d(branch_d), .mem_to_reg_d(mem_to_reg_d),
    .stall_e(stall_e), .flush_e(flush_e), .alu_flags_e(alu_a),
    .cond_ex_e(a_cond_ex_e), .pc_src_e(a_pc_src_e), .branch_taken_e(a_branch_taken_e),
    .reg_write_e(a_reg_write_e), .mem_write_e(a_mem_write_e),
    .pc_src_m(a_pc_src_m), .reg_write_m(a_reg_write_m), .mem_write_m(a_mem_write_m),
    .mem_to_reg_m(a_mem_to_reg_m), .pc_src_w(a_pc_src_w), .reg_write_w(a_reg_write_w),
    .mem_to_reg_w(a_mem_to_reg_w), .flags_q(a_flags_q)
  );

  conditional_logic_pipe #(.NUM_FLAGS(6), .FLAG_GROUPS(3)) dut_b (
    .clk(clk), .rst(rst), .cond_d(cond_d), .flag_w_d(flag_w_b),
    .pcs_d(pcs_d), .reg_w_d(reg_w_d), .mem_w_d(mem_w_d), .no_write_d(no_write_d),
    .branch_d(branch_d), .mem_to_reg_d(mem_to_reg_d),
    .stall_e(stall_e), .flush_e(flush_e), .alu_flags_e(alu_b),
    .cond_ex_e(b_cond_ex_e), .pc_src_e(b_pc_src_e), .branch_taken_e(b_branch_taken_e),
    .reg_write_e(b_reg_write_e), .mem_write_e(b_mem_write_e),
    .pc_src_m(b_pc_src_m), .reg_write_m(b_reg_write_m), .mem_write_m(b_mem_write_m),
    .mem_to_reg_m(b_mem_to_reg_m), .pc_src_w(b_pc_src_w), .reg_write_w(b_reg_write_w),
    .mem_to_reg_w(b_mem_to_reg_w), .flags_q(b_flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] cond;
    logic       pcs, rw, mw, nw, br, mtr;
    logic [2:0] fw;
  } ins_t;

  typedef struct packed {
    logic [11:0] ca;
    logic [3:0]  fa;
    logic [11:0] cb;
    logic [5:0]  fb;
  } exp_t;

  ins_t       e_ins  [2];
  logic [5:0] mflags [2];
  logic [3:0] mst    [2];  // {pc, rw, mw, mtr} in Memory
  logic [2:0] wst    [2];  // {pc, rw, mtr} in Writeback
  int         nfl    [2];
  int         ngr    [2];

  exp_t q[$];
  logic mon_en;
  int   vectors;
  int   errors;

  function automatic logic passes(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] nzcv_of(input int k);
    return mflags[k][nfl[k]-1 -: 4];
  endfunction

  function automatic logic [11:0] ctl_of(input int k);
    logic ok;
    ok = passes(e_ins[k].cond, nzcv_of(k));
    return {ok, e_ins[k].pcs & ok, e_ins[k].br & ok, e_ins[k].rw & !e_ins[k].nw & ok,
            e_ins[k].mw & ok, mst[k], wst[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_ins[k]  = '0;
      mflags[k] = '0;
      mst[k]    = '0;
      wst[k]    = '0;
    end
  endtask

  // Advance one clock edge for instance k
  task automatic model_step(input int k, input ins_t d, input logic [5:0] alu,
                            input logic st, input logic fl);
    logic ok, gpc, grw, gmw;
    int   w;
    ins_t cur;
    cur = e_ins[k];
    ok  = passes(cur.cond, nzcv_of(k));
    gpc = cur.pcs & ok;
    grw = cur.rw & !cur.nw & ok;
    gmw = cur.mw & ok;
    w   = nfl[k] / ngr[k];
    for (int g = 0; g < ngr[k]; g++)
      if (cur.fw[g] && ok && !st)
        for (int b = g * w; b < (g + 1) * w; b++) mflags[k][b] = alu[b];
    wst[k] = {mst[k][3], mst[k][2], mst[k][0]};
    mst[k] = st ? 4'b0 : {gpc, grw, gmw, cur.mtr};
    if (fl) begin
      e_ins[k]      = '0;
      e_ins[k].cond = 4'hE;
    end else if (!st) begin
      e_ins[k] = d;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_ctl_a();
    return {a_cond_ex_e, a_pc_src_e, a_branch_taken_e, a_reg_write_e, a_mem_write_e,
            a_pc_src_m, a_reg_write_m, a_mem_write_m, a_mem_to_reg_m,
            a_pc_src_w, a_reg_write_w, a_mem_to_reg_w};
  endfunction

  function automatic logic [11:0] dut_ctl_b();
    return {b_cond_ex_e, b_pc_src_e, b_branch_taken_e, b_reg_write_e, b_mem_write_e,
            b_pc_src_m, b_reg_write_m, b_mem_write_m, b_mem_to_reg_m,
            b_pc_src_w, b_reg_write_w, b_mem_to_reg_w};
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, "_ctl_a"},   32'(dut_ctl_a()), 32'(e.ca));
    check({tag, "_flags_a"}, 32'(a_flags_q),   32'(e.fa));
    check({tag, "_ctl_b"},   32'(dut_ctl_b()), 32'(e.cb));
    check({tag, "_flags_b"}, 32'(b_flags_q),   32'(e.fb));
  endtask

  // One cycle of stimulus: drive at negedge, predict the post-edge state
  task automatic drive(input logic [3:0] cond, input logic pcs, input logic rw,
                       input logic mw, input logic nw, input logic br, input logic mtr,
                       input logic [1:0] fwa, input logic [3:0] alua,
                       input logic [2:0] fwb, input logic [5:0] alub,
                       input logic st, input logic fl);
    ins_t da, db;
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    cond_d = cond; pcs_d = pcs; reg_w_d = rw; mem_w_d = mw; no_write_d = nw;
    branch_d = br; mem_to_reg_d = mtr; stall_e = st; flush_e = fl;
    flag_w_a = fwa; alu_a = alua; flag_w_b = fwb; alu_b = alub;
    da = '{cond: cond, pcs: pcs, rw: rw, mw: mw, nw: nw, br: br, mtr: mtr, fw: {1'b0, fwa}};
    db = da;
    db.fw = fwb;
    model_step(0, da, {2'b00, alua}, st, fl);
    model_step(1, db, alub, st, fl);
    e.ca = ctl_of(0);
    e.fa = mflags[0][3:0];
    e.cb = ctl_of(1);
    e.fb = mflags[1];
    q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic nop(input logic [3:0] alua, input logic st, input logic fl);
    drive(4'hE, 0, 0, 0, 0, 0, 0, 2'b00, alua, 3'($urandom), 6'($urandom), st, fl);
  endtask

  task automatic rand_cycle();
    drive(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 3'($urandom),
          6'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
        end else begin
          e = q.pop_front();
          check_all("cyc", e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t zero;
    zero    = '0;
    vectors = 0;
    errors  = 0;
    mon_en  = 1'b0;
    nfl[0] = 4; ngr[0] = 2;
    nfl[1] = 6; ngr[1] = 3;
    rst = 1'b0;
    cond_d = '0; pcs_d = 0; reg_w_d = 0; mem_w_d = 0; no_write_d = 0;
    branch_d = 0; mem_to_reg_d = 0; stall_e = 0; flush_e = 0;
    flag_w_a = '0; alu_a = '0; flag_w_b = '0; alu_b = '0;
    model_reset();
    #1 rst = 1'b1;
    #2 check_all("reset", zero);

    // EQ fails on Z=0, AL sets Z via group 1, next EQ passes and flows to M, W
    drive(4'h0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000, 6'h00, 0, 0);
    drive(4'hE, 0, 0, 0, 0, 0, 0, 2'b10, 4'h0, 3'b110, 6'h00, 0, 0);
    drive(4'h0, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0100, 3'b000, 6'b010000, 0, 0);
    nop(4'h0, 0, 0);
    nop(4'h0, 0, 0);
    // Group independence: clear, then write only the low group
    drive(4'hE, 0, 0, 0, 0, 0, 0, 2'b11, 4'h0, 3'b111, 6'h00, 0, 0);
    drive(4'hE, 0, 0, 0, 0, 0, 0, 2'b01, 4'h0, 3'b001, 6'h00, 0, 0);
    nop(4'hF, 0, 0);
    // Conditional flag set that fails (NE with Z=1)
    drive(4'hE, 0, 0, 0, 0, 0, 0, 2'b11, 4'h0, 3'b111, 6'h00, 0, 0);
    drive(4'h1, 1, 0, 1, 0, 0, 0, 2'b11, 4'b0100, 3'b111, 6'b010000, 0, 0);
    nop(4'b1000, 0, 0);
    // Two-cycle stall on a flag-setting store
    drive(4'hE, 0, 0, 1, 0, 0, 0, 2'b11, 4'h0, 3'b111, 6'h00, 0, 0);
    nop(4'b1010, 1, 0);
    nop(4'b1010, 1, 0);
    nop(4'b1010, 0, 0);
    nop(4'h0, 0, 0);
    nop(4'h0, 0, 0);
    // Flush and stall together against a pending branch
    nop(4'h0, 0, 0);
    drive(4'hE, 1, 0, 0, 0, 1, 0, 2'b00, 4'h0, 3'b000, 6'h00, 1, 1);
    nop(4'h0, 0, 0);
    for (int i = 0; i < 20; i++) rand_cycle();

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst", zero);
    @(posedge clk);
    #1;
    check_all("rst_held", zero);

    for (int i = 0; i < 300; i++) rand_cycle();

    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
